// File: rtl/branch_pkg.sv
// Shared types and constants for the branch control front end:
// FSM states, branch opcode/condition encodings, HALT word and relative-target LUT.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_HALTED
  } state_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_ZERO   = 2'b01,
    COND_NZERO  = 2'b10,
    COND_NEG    = 2'b11
  } cond_e;

  localparam int INSTR_W = 9;
  localparam int OFFS_W  = 10;

  localparam logic [2:0]         OP_BRANCH  = 3'b110;
  localparam logic [INSTR_W-1:0] INSTR_HALT = '1;

  // Relative jump offsets selected by the low nibble of a branch instruction
  localparam logic signed [OFFS_W-1:0] TARGET_LUT [16] = '{
    10'sd2,  10'sd4,   -10'sd2,  -10'sd5,
    10'sd8,  -10'sd8,  10'sd16,  -10'sd16,
    10'sd3,  -10'sd3,  10'sd32,  -10'sd32,
    10'sd1,  -10'sd1,  10'sd64,  -10'sd64
  };

endpackage

// File: rtl/branch_ctl_if.sv
// Bench/counter-facing handshake and decode bus of branch_ctl.
// slave: branch_ctl side; master: driver of Start/Instr/ProgCtr/flags.
interface branch_ctl_if #(
  parameter int A = 10,
  parameter int W = 9
);
  logic         Start;
  logic [W-1:0] Instr;
  logic [A-1:0] ProgCtr;
  logic         Zero;
  logic         Neg;
  logic         Branch;
  logic [A-1:0] Target;
  logic         Done;

  modport slave (
    input  Start, Instr, ProgCtr, Zero, Neg,
    output Branch, Target, Done
  );

  modport master (
    output Start, Instr, ProgCtr, Zero, Neg,
    input  Branch, Target, Done
  );
endinterface

// File: rtl/start_edge.sv
// Registers the Start level and emits one-cycle rise/fall pulses.
module start_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  output logic rise,
  output logic fall
);
  logic start_r;

  always_ff @(posedge Clk) begin
    if (Reset) start_r <= 1'b0;
    else       start_r <= start;
  end

  assign rise = start & ~start_r;
  assign fall = start_r & ~start;
endmodule

// File: rtl/branch_ctl.sv
// Control-flow front end driving the program counter's Branch/Target inputs.
// Optional CYCLE_COUNT_EN adds a saturating RUN-cycle counter output.
module branch_ctl
  import branch_pkg::*;
#(
  parameter int A     = 10,
  parameter int W     = 9,
  parameter int BASE1 = 0,
  parameter int BASE2 = 100,
  parameter int BASE3 = 200
) (
  input  logic        Clk,
  input  logic        Reset,
`ifdef CYCLE_COUNT_EN
  output logic [15:0] CycleCount,
`endif
  branch_ctl_if.slave bus
);
  state_e     state;
  logic [1:0] prog_sel;
  logic       done;
  logic       rise, fall;

  start_edge u_start_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .start (bus.Start),
    .rise  (rise),
    .fall  (fall)
  );

  logic [A-1:0] base_addr;
  logic         is_halt, is_branch, taken;
  cond_e        cond;

  always_comb begin
    case (prog_sel)
      2'd1:    base_addr = A'(BASE1);
      2'd2:    base_addr = A'(BASE2);
      2'd3:    base_addr = A'(BASE3);
      default: base_addr = '0;
    endcase
  end

  assign is_halt   = (bus.Instr == W'(INSTR_HALT));
  assign is_branch = (bus.Instr[W-1 -: 3] == OP_BRANCH);
  assign cond      = cond_e'(bus.Instr[5:4]);

  always_comb begin
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_ZERO:   taken = bus.Zero;
      COND_NZERO:  taken = ~bus.Zero;
      COND_NEG:    taken = bus.Neg;
      default:     taken = 1'b0;
    endcase
  end

  // Freezing is PC+0, so every non-running cycle asks for Branch with zero offset
  always_comb begin
    bus.Branch = 1'b1;
    bus.Target = '0;
    if (!Reset) begin
      case (state)
        ST_LAUNCH: bus.Target = base_addr - bus.ProgCtr;
        ST_RUN: begin
          if (is_halt) begin
            bus.Target = '0;
          end else if (is_branch && taken) begin
            bus.Target = A'(TARGET_LUT[bus.Instr[3:0]]);
          end else begin
            bus.Branch = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      prog_sel <= 2'd0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (rise && prog_sel != 2'd3) prog_sel <= prog_sel + 2'd1;
          if (fall && prog_sel != 2'd0) state <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          state <= ST_RUN;
          done  <= 1'b0;
        end
        ST_RUN: begin
          if (is_halt) begin
            state <= ST_HALTED;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Done = done;

`ifdef CYCLE_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset)                                 CycleCount <= '0;
    else if (state == ST_LAUNCH)               CycleCount <= '0;
    else if (state == ST_RUN && CycleCount != 16'hFFFF) CycleCount <= CycleCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_branch_ctl.sv
// Scoreboard bench for branch_ctl: a driver models the program flow and queues
// expected outputs; a negedge monitor pops and compares.
module tb_branch_ctl;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  branch_ctl_if #(.A(10), .W(9)) bus ();
`ifdef CYCLE_COUNT_EN
  logic [15:0] CycleCount;
`endif

  branch_ctl #(.A(10), .W(9), .BASE1(0), .BASE2(100), .BASE3(200)) dut (
    .Clk   (Clk),
    .Reset (Reset),
`ifdef CYCLE_COUNT_EN
    .CycleCount (CycleCount),
`endif
    .bus   (bus)
  );

  typedef struct {
    logic       b;
    logic [9:0] t;
    logic       d;
    int         cc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int lut[16]  = '{2, 4, -2, -5, 8, -8, 16, -16, 3, -3, 32, -32, 1, -1, 64, -64};
  int bases[4] = '{0, 0, 100, 200};

  // Program-flow model: where we are in the program life cycle, not FSM bits
  bit         running = 0, launch_now = 0, done_m = 0, prev_s = 0;
  int         progs = 0;
  int         cc_m = 0;
  logic [9:0] pc = '0;

  task automatic step(input logic s, input logic [8:0] ins, input logic z,
                      input logic n, input logic rst);
    exp_t e;
    bit   tk, halt, rise, fall;
    @(posedge Clk);
    #1;
    Reset       = rst;
    bus.Start   = s;
    bus.Instr   = ins;
    bus.ProgCtr = pc;
    bus.Zero    = z;
    bus.Neg     = n;

    halt = (ins == 9'h1FF);
    case (ins[5:4])
      2'b00:   tk = 1;
      2'b01:   tk = z;
      2'b10:   tk = !z;
      default: tk = n;
    endcase
    tk = tk && (ins[8:6] == 3'b110);

    e.b = 1; e.t = '0; e.d = done_m; e.cc = cc_m;
    if (!rst) begin
      if (launch_now)   e.t = 10'(bases[progs] - int'(pc));
      else if (running) begin
        if (halt)       e.t = '0;
        else if (tk)    e.t = 10'(lut[ins[3:0]]);
        else            e.b = 0;
      end
    end
    sb.push_back(e);

    pc = e.b ? pc + e.t : pc + 10'd1;

    if (rst) begin
      running = 0; launch_now = 0; done_m = 0; prev_s = 0; progs = 0; cc_m = 0;
    end else begin
      rise = s && !prev_s;
      fall = !s && prev_s;
      prev_s = s;
      if (launch_now) begin
        launch_now = 0; running = 1; done_m = 0; cc_m = 0;
      end else if (running) begin
        if (cc_m < 65535) cc_m++;
        if (halt) begin running = 0; done_m = 1; end
      end else begin
        if (rise && progs < 3) progs++;
        if (fall && progs != 0) launch_now = 1;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 9'h000, 0, 0, 0);
  endtask

  // Start high two cycles, then the falling-edge cycle, then the LAUNCH cycle
  task automatic pulse_and_launch();
    step(1, 9'h000, 0, 0, 0);
    step(1, 9'h000, 0, 0, 0);
    step(0, 9'h000, 0, 0, 0);
    step(0, 9'h000, 0, 0, 0);
  endtask

  function automatic logic [8:0] rand_instr();
    logic [8:0] v;
    v = 9'($urandom);
    if ($urandom_range(0, 2) == 0) v[8:6] = 3'b110;
    if (v == 9'h1FF) v = 9'h0FF;
    return v;
  endfunction

  task automatic run_random(input int k, input logic s);
    for (int i = 0; i < k; i++)
      step(s, rand_instr(), 1'($urandom), 1'($urandom), 0);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.Branch !== e.b) begin
        errors++;
        $display("FAIL branch t=%0t got=%b want=%b", $time, bus.Branch, e.b);
      end
      if (e.b) begin
        checks++;
        if (bus.Target !== e.t) begin
          errors++;
          $display("FAIL target t=%0t got=%h want=%h", $time, bus.Target, e.t);
        end
      end
      checks++;
      if (bus.Done !== e.d) begin
        errors++;
        $display("FAIL done t=%0t got=%b want=%b", $time, bus.Done, e.d);
      end
`ifdef CYCLE_COUNT_EN
      checks++;
      if (CycleCount !== 16'(e.cc)) begin
        errors++;
        $display("FAIL cyclecount t=%0t got=%0d want=%0d", $time, CycleCount, e.cc);
      end
`endif
    end
  end

  initial begin
    Reset = 1'b1;
    bus.Start = 0; bus.Instr = '0; bus.ProgCtr = '0; bus.Zero = 0; bus.Neg = 0;

    repeat (2) step(0, 9'h000, 0, 0, 1);
    pc = '0;
    idle(10);

    // Program 1 at BASE1 with directed decode cases
    pulse_and_launch();
    step(0, 9'h012, 0, 0, 0);
    step(0, 9'h183, 0, 0, 0);
    step(0, 9'h191, 0, 0, 0);
    step(0, 9'h191, 1, 0, 0);
    run_random(20, 0);
    pc = 10'd37;
    step(0, 9'h1FF, 0, 0, 0);
    idle(2);

    // Program 2 from PC 37: offset 63; Start toggles during RUN are ignored
    pulse_and_launch();
    run_random(10, 0);
    run_random(3, 1);
    run_random(12, 0);
    step(0, 9'h1FF, 0, 0, 0);
    idle(2);

    // Program 3, then a fourth request saturates at program 3
    pulse_and_launch();
    run_random(15, 0);
    step(0, 9'h1FF, 0, 0, 0);
    idle(2);
    pulse_and_launch();
    run_random(10, 0);

    // Reset mid-RUN, then relaunch program 1
    step(0, rand_instr(), 0, 0, 1);
    idle(3);
    pulse_and_launch();
    run_random(20, 0);
    step(0, 9'h1FF, 0, 0, 0);
    idle(2);

    @(negedge Clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_ctl.md
# branch_ctl

Control-flow front end paired with the program counter register. Each cycle it decodes the fetched instruction and ALU flags and drives the counter's `Branch`/`Target` inputs. It runs the test-bench `Start` handshake: freeze while idle, jump to the selected program's base address, detect HALT, and report `Done`. It holds no PC state of its own. It only ever asks the counter to add `Target`; any other cycle the counter increments.

## Interface
- `A`, 10: PC / target width; `Target` is an A-bit two's-complement relative offset.
- `W`, 9: instruction width.
- `BASE1`, `BASE2`, `BASE3`, 0 / 100 / 200: start addresses of programs 1–3.
- `Clk` in 1: clock; all state changes on posedge.
- `Reset` in 1: reset, synchronous, active-high.
- `Start` in 1: bench program request; level, held ≥1 cycle.
- `Instr` in W: instruction at current `ProgCtr`.
- `ProgCtr` in A: current PC value.
- `Zero` in 1: registered ALU zero flag.
- `Neg` in 1: registered ALU negative flag.
- `Branch` out 1: counter adds `Target` this edge when 1.
- `Target` out A: relative offset; meaningful only when `Branch`=1.
- `Done` out 1: program finished; registered.

## Operation
- States: IDLE, LAUNCH, RUN, HALTED; reset → IDLE, `ProgSel`=0, `start_r`=0, `Done`=0.
- Freeze (IDLE, HALTED): `Branch`=1, `Target`=0, so PC+0 holds the PC. During `Reset`, `Branch`=1 and `Target`=0.
- `Start` rising edge (`!start_r && Start`) in IDLE/HALTED: `ProgSel` increments, saturating at 3.
- `Start` falling edge (`start_r && !Start`) in IDLE/HALTED with `ProgSel`≠0: next state LAUNCH.
- `Start` edges in LAUNCH/RUN are ignored; `start_r` still tracks `Start`.
- LAUNCH (one cycle): `Branch`=1, `Target` = (BASE[ProgSel] − `ProgCtr`) mod 2^A. Next state RUN. `Done`←0.
- RUN decode:
  - `Instr`==all-ones is HALT: `Branch`=1, `Target`=0, next state HALTED, `Done`←1.
  - `Instr[W-1:W-3]`==3'b110 is a branch. Condition `Instr[5:4]`: 00 always, 01 `Zero`, 10 `!Zero`, 11 `Neg`.
  - Branch taken: `Branch`=1, `Target`=LUT[`Instr[3:0]`]. Not taken: `Branch`=0.
  - Any other instruction: `Branch`=0.
- LUT: 16 constant A-bit signed offsets from the package. PC arithmetic wraps mod 2^A, with no overflow detection.
- HALTED → LAUNCH on the next qualifying falling edge. `Done` stays 1 until LAUNCH.
- `Reset` mid-RUN returns to IDLE and clears `ProgSel` and `Done`.

## Timing
- `Branch`/`Target` are combinational from state, `Instr`, `Zero`, `Neg`, `ProgCtr`. Zero-latency: they take effect at the same posedge.
- Falling edge of `Start` is seen in cycle n. LAUNCH is cycle n+1. RUN begins at cycle n+2 with PC=BASE.
- HALT is decoded in cycle m. `Done`=1 and state HALTED from cycle m+1.
- `Start` rising and falling within one sample is not detected. The bench must hold `Start` high ≥1 full cycle.

## Configuration
- `CYCLE_COUNT_EN` defined:
  - Adds output `CycleCount` [15:0], reset 0.
  - Cleared in LAUNCH; +1 each RUN cycle including the HALT cycle; saturates at 16'hFFFF.
  - Holds in HALTED/IDLE.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- `branch_pkg`: state enum, opcode constant 3'b110, HALT constant, condition enum, 16-entry target LUT constant array.
- One sub-module `start_edge`: registers `start_r` and outputs one-cycle `rise`/`fall` pulses.

## Test plan
- Reset 2 cycles, then 10 idle cycles with `ProgCtr`=0 → `Branch`=1, `Target`=0, `Done`=0 every cycle.
- `Start` high 2 cycles then low → one LAUNCH cycle with `Target`=0 (BASE1). Next cycle, non-branch `Instr`=9'h012 → `Branch`=0.
- RUN, `Instr`=9'h183 (always, idx 3), LUT[3]=10'h3FB → `Branch`=1, `Target`=10'h3FB.
- RUN, `Instr`=9'h191 (BZ idx 1): `Zero`=0 → `Branch`=0; `Zero`=1 → `Branch`=1, `Target`=LUT[1].
- HALT at `ProgCtr`=37 → `Branch`=1, `Target`=0, `Done`=1 next cycle. Second `Start` pulse → LAUNCH `Target`=63 (100−37), `Done`=0.
- Fourth `Start` → `ProgSel` stays 3; LAUNCH targets 200. `Reset` asserted mid-RUN → IDLE, `Done`=0. A later pulse relaunches BASE1.
